// File: rtl/pix_if.sv
// pix_if: valid/ready raster pixel stream from an upstream source into the binarizer.
interface pix_if #(
    parameter int W = 8
);
    logic         valid;
    logic [W-1:0] data;
    logic         last;
    logic         ready;
    modport master (output valid, data, last, input ready);
    modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/pixel_frame_binarizer.sv
// pixel_frame_binarizer: thresholds a pixel raster into a feature vector and sequences the classifier.
module pixel_frame_binarizer #(
    parameter int NUM_PIXELS     = 784,
    parameter int PIXEL_WIDTH    = 8,
    parameter int THRESHOLD      = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    pix_if.slave                  pix,
    output logic [NUM_PIXELS-1:0] features,
    output logic                  start,
    input  logic                  nn_done,
    input  logic [3:0]            nn_prediction,
    output logic [3:0]            result,
    output logic                  result_valid,
    output logic                  frame_error,
    output logic                  timeout_error,
    output logic                  busy
);
    localparam int IW = $clog2(NUM_PIXELS);
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PIXELS - 1);
    localparam logic [WW-1:0] LAST_WD = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [PIXEL_WIDTH-1:0] THR = PIXEL_WIDTH'(THRESHOLD);

    typedef enum logic [1:0] {COLLECT, DISCARD, LAUNCH, WAIT} state_t;

    state_t        state, state_n;
    logic [IW-1:0] pix_idx, pix_idx_n;
    logic [WW-1:0] wdog, wdog_n;
    logic          accept, at_end, frame_err_n, timeout_n, capture;

    assign accept = pix.valid && pix.ready;
    assign at_end = pix_idx == LAST_IDX;

    // nn_done is only looked at in WAIT, so a stale level during LAUNCH cannot complete a frame
    always_comb begin
        state_n     = state;
        pix_idx_n   = pix_idx;
        wdog_n      = wdog;
        frame_err_n = 1'b0;
        timeout_n   = 1'b0;
        capture     = 1'b0;
        case (state)
            COLLECT: if (accept) begin
                pix_idx_n   = (at_end || pix.last) ? '0 : pix_idx + 1'b1;
                frame_err_n = at_end != pix.last;
                state_n     = at_end ? (pix.last ? LAUNCH : DISCARD) : COLLECT;
            end
            DISCARD: state_n = (accept && pix.last) ? COLLECT : DISCARD;
            LAUNCH: begin
                wdog_n  = '0;
                state_n = WAIT;
            end
            WAIT: if (nn_done) begin
                capture = 1'b1;
                state_n = COLLECT;
            end else if (wdog == LAST_WD) begin
                timeout_n = 1'b1;
                state_n   = COLLECT;
            end else begin
                wdog_n = wdog + 1'b1;
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COLLECT;
            pix_idx       <= '0;
            wdog          <= '0;
            features      <= '0;
            start         <= 1'b0;
            result        <= '0;
            result_valid  <= 1'b0;
            frame_error   <= 1'b0;
            timeout_error <= 1'b0;
            busy          <= 1'b0;
            pix.ready     <= 1'b0;
        end else begin
            state         <= state_n;
            pix_idx       <= pix_idx_n;
            wdog          <= wdog_n;
            if (state == COLLECT && accept) features[pix_idx] <= pix.data >= THR;
            start         <= state_n == LAUNCH;
            busy          <= state_n == LAUNCH || state_n == WAIT;
            pix.ready     <= state_n == COLLECT || state_n == DISCARD;
            result_valid  <= capture;
            if (capture) result <= nn_prediction;
            frame_error   <= frame_err_n;
            timeout_error <= timeout_n;
        end
    end
endmodule
